// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory port between the instruction-fetch requester
//   (i_*) and the load/store data requester (d_*). One transaction at a time:
//   IDLE grants a requester and registers its request onto the memory port,
//   MEM waits for m_ack (or the optional watchdog), RESP pulses the winner's
//   ack (with err on timeout) for one cycle before returning to IDLE.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  memory wait limit in cycles (1..65535), 0 disables the watchdog
//
// Ports
//   clk, reset_n                   clock, synchronous active-low reset
//   i_req, i_addr                  fetch request / address
//   i_rdata, i_ack, i_err          fetch data (registered), done pulse, timeout flag
//   d_req, d_we, d_addr, d_wdata   data request, store enable, address, store data
//   d_rdata, d_ack, d_err          load data (registered), done pulse, timeout flag
//   m_req, m_we, m_addr, m_wdata   memory request side, all registered
//   m_rdata, m_ack                 memory response
//   busy                           high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  // Wait counter stops at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]  state;
  logic        last_grant_d;   // 1: D won the previous grant, 0: I
  logic        owner_d;        // 1: current transaction belongs to D
  logic [15:0] wait_cnt;

  logic any_req;
  logic pick_d;
  logic to_hit;

  // On a tie the requester that did not win last time gets the port.
  assign any_req = i_req | d_req;
  assign pick_d  = d_req & (~i_req | ~last_grant_d);
  assign to_hit  = TO_EN && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      last_grant_d <= 1'b0;
      owner_d      <= 1'b0;
      wait_cnt     <= 16'd0;
      busy         <= 1'b0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_err        <= 1'b0;
      d_err        <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses, raised only on entry to RESP
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;

      case (state)
        // IDLE: grant and register the winning request
        S_IDLE: begin
          if (any_req) begin
            state        <= S_MEM;
            busy         <= 1'b1;
            m_req        <= 1'b1;
            owner_d      <= pick_d;
            last_grant_d <= pick_d;
            wait_cnt     <= 16'd0;
            if (pick_d) begin
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end else begin
              m_addr  <= i_addr;
              m_we    <= 1'b0;
              m_wdata <= '0;
            end
          end
        end

        // MEM: wait for the memory; an ack in the timeout cycle still wins
        S_MEM: begin
          if (m_ack) begin
            state <= S_RESP;
            m_req <= 1'b0;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else if (to_hit) begin
            state <= S_RESP;
            m_req <= 1'b0;
            if (owner_d) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end else begin
              i_ack <= 1'b1;
              i_err <= 1'b1;
            end
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end

        // RESP: ack pulse is on the outputs this cycle; requests not sampled
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between the instruction-fetch requester and the load/store data requester (the path driven by the control decoder's `ram_rd`/`ram_we`). It arbitrates per transaction, registers the winning request onto the memory port, and waits for the memory acknowledge. It then returns read data and a one-cycle acknowledge (or a timeout error) to the winner. It sits between the CPU core and the memory/bus interface.

## Interface

**Parameters**
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 0: memory wait limit in cycles, 1..65535. 0 disables the watchdog.

**Ports**
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  instruction fetch request.
- `i_addr`  in  AW  fetch address.
- `i_rdata`  out  DW  fetch data, registered.
- `i_ack`  out  1  fetch complete, one-cycle pulse.
- `i_err`  out  1  fetch timed out; valid only with `i_ack`.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data, registered.
- `d_ack`  out  1  data complete, one-cycle pulse.
- `d_err`  out  1  data timed out; valid only with `d_ack`.
- `m_req`  out  1  memory request; held until ack or timeout.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  memory address, registered.
- `m_wdata`  out  DW  memory write data, registered.
- `m_rdata`  in  DW  memory read data; valid with `m_ack`.
- `m_ack`  in  1  memory completion.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation

**States:** IDLE, MEM, RESP.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one of `i_req`/`d_req` is high, grant it.
  - If both are high, grant the requester not granted last (`last_grant` register). `last_grant` resets to I, so D wins the first tie.
  - On grant: next state MEM. `m_req`←1. `m_addr`, `m_we`, `m_wdata` are loaded from the winner. For I, `m_we`←0 and `m_wdata`←0. `last_grant`←winner. `wait_cnt`←0.
- **MEM:**
  - If `m_ack`=1: next state RESP, `m_req`←0. On a read, capture `m_rdata` into the winner's rdata register.
  - Else, if `TIMEOUT`≠0 and `wait_cnt`==`TIMEOUT`-1: next state RESP, `m_req`←0, winner's err←1. The rdata register is unchanged.
  - Otherwise, `wait_cnt`++. `wait_cnt` is 16 bits and saturates; it never wraps.
- **RESP:**
  - Winner's ack=1 for exactly this cycle; err is 1 only if the transaction timed out.
  - Next state is always IDLE. Requests are not sampled in RESP.
- A store never updates `d_rdata`.
- `i_rdata`/`d_rdata` hold their last value until the next successful read.

**Requester rules**
- Hold `x_req`, address, `d_we` and `d_wdata` stable from assertion until the cycle `x_ack` is high.
- Deassert (or present a new request) from the following cycle.
- The arbiter samples address and data only at grant.

**Boundary conditions**
- `m_ack` while in IDLE or RESP is ignored; no state change.
- `m_ack` and timeout in the same MEM cycle: the ack wins and err stays 0.
- A requester dropping `x_req` while in MEM does not abort the transaction; its ack still pulses.

**Reset (`reset_n`=0 at a clock edge, in any state)**
- State←IDLE.
- `m_req`, `m_we`, `i_ack`, `d_ack`, `i_err`, `d_err`, `busy`←0.
- `m_addr`, `m_wdata`, `i_rdata`, `d_rdata`←0.
- `last_grant`←I, `wait_cnt`←0.
- An in-flight memory access is abandoned. A late `m_ack` after reset is ignored.

## Timing

- Request high in IDLE at cycle 0 → `m_req` high from cycle 1.
- `m_ack` sampled in cycle k (k≥1) → `x_ack` high in cycle k+1 → IDLE in cycle k+2, when a new grant is possible.
- Zero-wait memory (`m_ack` in cycle 1) gives a 3-cycle transaction and 1 transaction per 3 cycles.
- Timeout: `m_req` is high for exactly `TIMEOUT` cycles, then `x_ack`+`x_err` follow in the next cycle.
- All outputs are registered. No combinational path exists from any input to any output.

## Test plan

- **Reset:** hold `reset_n`=0 for 2 cycles with `i_req`=1 and `m_ack`=1. Required: all outputs 0, `busy`=0. After release, the I grant appears 1 cycle later.
- **Single fetch:** `i_req`=1, `i_addr`=0x100. Memory returns `m_ack` with `m_rdata`=0xDEADBEEF 2 cycles after `m_req`. Required: `m_addr`=0x100, `m_we`=0, `i_rdata`=0xDEADBEEF, `i_ack` high for 1 cycle, exactly 1 cycle after `m_ack`.
- **Tie and alternation:** `i_req` and `d_req` held continuously, ack on first MEM cycle. Required grant order: D, I, D, I. Each transaction lasts 3 cycles, and neither requester is starved.
- **Store:** `d_req`=1, `d_we`=1, `d_addr`=0x20, `d_wdata`=0x12345678, with `d_rdata` previously 0xAA. Required: `m_we`=1, `m_wdata`=0x12345678, `d_ack` pulses, `d_rdata` stays 0xAA.
- **Timeout:** `TIMEOUT`=4, memory never acks. Required: `m_req` high for exactly 4 cycles, then `d_ack`=`d_err`=1 for one cycle. Repeat with `m_ack` arriving in the 4th cycle → `d_err`=0.
- **Reset mid-MEM, then stray ack:** assert `reset_n`=0 during MEM, then send `m_ack` in IDLE. Required: IDLE, `m_req`=0, no `x_ack` pulse, rdata registers 0.
